// File: rtl/store_trace_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : store_trace_checker                                           |
// | Brief    : Compares core data-memory stores, in order, against a small   |
// |            programmed table of (address, data) pairs and flags a        |
// |            sticky pass/fail verdict, including an inactivity timeout.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module store_trace_checker #(
  parameter int          DEPTH       = 4,
  parameter int          TIMEOUT     = 64,
  parameter logic [31:0] IGNORE_ADDR = 32'd80,
  localparam int         IW          = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [IW:0]   exp_count,
  input  logic          exp_we,
  input  logic [IW-1:0] exp_idx,
  input  logic [31:0]   exp_addr,
  input  logic [31:0]   exp_data,
  input  logic          memwrite,
  input  logic [31:0]   dataadr,
  input  logic [31:0]   writedata,
  output logic          busy,
  output logic          pass,
  output logic          fail,
  output logic          timeout,
  output logic [IW-1:0] fail_idx,
  output logic [31:0]   fail_addr,
  output logic [31:0]   fail_data,
  output logic [IW:0]   store_cnt,
  output logic [7:0]    skip_cnt
);

  localparam logic [15:0] c_timer_last = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_t;

  state_t        r_state;
  logic [IW:0]   r_count;
  logic [IW-1:0] r_ptr;
  logic [15:0]   r_timer;
  logic          r_timeout;
  logic [IW-1:0] r_fail_idx;
  logic [31:0]   r_fail_addr;
  logic [31:0]   r_fail_data;
  logic [IW:0]   r_store_cnt;
  logic [7:0]    r_skip_cnt;

  // Expected-store table; deliberately not reset so it survives a reset pulse.
  logic [63:0]   r_tab [DEPTH];

  logic [63:0]   w_entry;
  logic          w_is_skip;
  logic          w_match;
  logic          w_mismatch;
  logic          w_last;
  logic          w_expire;

  assign w_entry    = r_tab[r_ptr];
  assign w_is_skip  = memwrite && (dataadr == IGNORE_ADDR);
  assign w_match    = memwrite && !w_is_skip && ({dataadr, writedata} == w_entry);
  assign w_mismatch = memwrite && !w_is_skip && !w_match;
  assign w_last     = ({1'b0, r_ptr} == (r_count - 1'b1));
  assign w_expire   = (r_timer == c_timer_last);

  // Table writes are locked out while a run is in progress.
  always_ff @(posedge clk) begin
    if (exp_we && (r_state != ST_RUN))
      r_tab[exp_idx] <= {exp_addr, exp_data};
  end

  // Run control: start handling, in-order store comparison and timeout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_count     <= '0;
      r_ptr       <= '0;
      r_timer     <= '0;
      r_timeout   <= 1'b0;
      r_fail_idx  <= '0;
      r_fail_addr <= '0;
      r_fail_data <= '0;
      r_store_cnt <= '0;
      r_skip_cnt  <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_match) begin
            // A match also wins over a coincident timer expiry.
            r_ptr       <= r_ptr + 1'b1;
            r_store_cnt <= r_store_cnt + 1'b1;
            r_timer     <= '0;
            if (w_last)
              r_state <= ST_PASS;
          end else if (w_mismatch) begin
            r_state     <= ST_FAIL;
            r_fail_idx  <= r_ptr;
            r_fail_addr <= dataadr;
            r_fail_data <= writedata;
          end else begin
            // Skipped stores count but do not refresh the inactivity timer.
            if (w_is_skip && (r_skip_cnt != 8'hFF))
              r_skip_cnt <= r_skip_cnt + 1'b1;
            if (w_expire) begin
              r_state    <= ST_FAIL;
              r_timeout  <= 1'b1;
              r_fail_idx <= r_ptr;
            end else begin
              r_timer <= r_timer + 1'b1;
            end
          end
        end
        default: begin
          if (start) begin
            r_count     <= exp_count;
            r_ptr       <= '0;
            r_timer     <= '0;
            r_timeout   <= 1'b0;
            r_fail_idx  <= '0;
            r_fail_addr <= '0;
            r_fail_data <= '0;
            r_store_cnt <= '0;
            r_skip_cnt  <= '0;
            r_state     <= (exp_count == '0) ? ST_PASS : ST_RUN;
          end
        end
      endcase
    end
  end

  assign busy      = (r_state == ST_RUN);
  assign pass      = (r_state == ST_PASS);
  assign fail      = (r_state == ST_FAIL);
  assign timeout   = r_timeout;
  assign fail_idx  = r_fail_idx;
  assign fail_addr = r_fail_addr;
  assign fail_data = r_fail_data;
  assign store_cnt = r_store_cnt;
  assign skip_cnt  = r_skip_cnt;

endmodule
`default_nettype wire

// File: tb/tb_store_trace_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_store_trace_checker                                        |
// | Brief    : Directed and randomized bench for store_trace_checker with a  |
// |            behavioural reference model of the checker's verdict rules.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_store_trace_checker;

  localparam int          DEPTH   = 4;
  localparam int          IW      = 2;
  localparam int          TIMEOUT = 8;
  localparam logic [31:0] IGN     = 32'd80;

  logic          clk       = 1'b0;
  logic          reset     = 1'b0;
  logic          start     = 1'b0;
  logic [IW:0]   exp_count = '0;
  logic          exp_we    = 1'b0;
  logic [IW-1:0] exp_idx   = '0;
  logic [31:0]   exp_addr  = '0;
  logic [31:0]   exp_data  = '0;
  logic          memwrite  = 1'b0;
  logic [31:0]   dataadr   = '0;
  logic [31:0]   writedata = '0;

  logic          busy, pass, fail, timeout;
  logic [IW-1:0] fail_idx;
  logic [31:0]   fail_addr, fail_data;
  logic [IW:0]   store_cnt;
  logic [7:0]    skip_cnt;

  store_trace_checker #(
    .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .IGNORE_ADDR(IGN)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .exp_count(exp_count),
    .exp_we(exp_we), .exp_idx(exp_idx), .exp_addr(exp_addr), .exp_data(exp_data),
    .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .busy(busy), .pass(pass), .fail(fail), .timeout(timeout),
    .fail_idx(fail_idx), .fail_addr(fail_addr), .fail_data(fail_data),
    .store_cnt(store_cnt), .skip_cnt(skip_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: phase 0=idle 1=running 2=passed 3=failed
  logic [31:0] m_a [DEPTH];
  logic [31:0] m_d [DEPTH];
  int          m_phase, m_n, m_pos, m_matched, m_skips, m_quiet, m_fidx;
  logic [31:0] m_faddr, m_fdata;
  bit          m_to;

  task automatic model_clear();
    m_phase = 0; m_n = 0; m_pos = 0; m_matched = 0; m_skips = 0;
    m_quiet = 0; m_fidx = 0; m_faddr = 0; m_fdata = 0; m_to = 0;
  endtask

  task automatic model_update();
    if (m_phase != 1 && exp_we) begin
      m_a[exp_idx] = exp_addr;
      m_d[exp_idx] = exp_data;
    end
    if (m_phase != 1) begin
      if (start) begin
        model_clear();
        m_n     = int'(exp_count);
        m_phase = (m_n == 0) ? 2 : 1;
      end
      return;
    end
    if (memwrite && dataadr == IGN) begin
      if (m_skips < 255) m_skips++;
    end else if (memwrite && dataadr == m_a[m_pos] && writedata == m_d[m_pos]) begin
      m_pos++; m_matched++; m_quiet = 0;
      if (m_pos == m_n) m_phase = 2;
      return;
    end else if (memwrite) begin
      m_phase = 3; m_fidx = m_pos; m_faddr = dataadr; m_fdata = writedata;
      return;
    end
    if (m_quiet == TIMEOUT - 1) begin
      m_phase = 3; m_to = 1; m_fidx = m_pos;
    end else begin
      m_quiet++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("busy",      32'(busy),      32'(m_phase == 1));
    chk("pass",      32'(pass),      32'(m_phase == 2));
    chk("fail",      32'(fail),      32'(m_phase == 3));
    chk("timeout",   32'(timeout),   32'(m_to));
    chk("fail_idx",  32'(fail_idx),  32'(m_fidx));
    chk("fail_addr", fail_addr,      m_faddr);
    chk("fail_data", fail_data,      m_fdata);
    chk("store_cnt", 32'(store_cnt), 32'(m_matched));
    chk("skip_cnt",  32'(skip_cnt),  32'(m_skips));
  endtask

  // One clock: model sees the same inputs the DUT samples, then compare.
  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    check_all();
    start = 0; exp_we = 0; memwrite = 0;
  endtask

  task automatic prog(input int idx, input logic [31:0] a, input logic [31:0] d);
    exp_we = 1; exp_idx = IW'(idx); exp_addr = a; exp_data = d;
    tick();
  endtask

  task automatic do_start(input int n);
    start = 1; exp_count = (IW+1)'(n);
    tick();
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    memwrite = 1; dataadr = a; writedata = d;
    tick();
  endtask

  initial begin
    model_clear();
    reset = 0;
    repeat (2) @(posedge clk);
    #1;
    check_all();
    reset = 1;

    // Skip then match: single-entry pass
    prog(0, 32'd84, 32'd7);
    do_start(1);
    store(32'd80, 32'd3);
    chk("skip_one", 32'(skip_cnt), 32'd1);
    store(32'd84, 32'd7);
    chk("pass_one", 32'(pass), 32'd1);

    // Data mismatch
    do_start(1);
    store(32'd84, 32'd6);
    chk("mm_fail", 32'(fail), 32'd1);
    chk("mm_data", fail_data, 32'd6);

    // Timeout exactly TIMEOUT cycles after busy rises
    do_start(1);
    repeat (TIMEOUT - 1) tick();
    chk("to_early", 32'(fail), 32'd0);
    tick();
    chk("to_fail", 32'(timeout), 32'd1);

    // Four entries, gapped stores, write attempt during run, then rerun
    for (int i = 0; i < 4; i++) prog(i, 32'(4 * i), 32'(i + 1));
    do_start(4);
    store(32'd0, 32'd1); tick(); tick();
    store(32'd4, 32'd2); tick();
    exp_we = 1; exp_idx = 2'd1; exp_addr = 32'hDEAD; exp_data = 32'hBEEF; tick();
    store(32'd8, 32'd3); tick(); tick(); tick();
    store(32'd12, 32'd4);
    chk("pass_four", 32'(store_cnt), 32'd4);
    do_start(4);
    for (int i = 0; i < 4; i++) store(32'(4 * i), 32'(i + 1));
    chk("rerun_pass", 32'(pass), 32'd1);

    // Empty run passes immediately
    do_start(0);
    chk("empty_pass", 32'(pass), 32'd1);
    tick();

    // Asynchronous reset mid-run, then restart with the retained table
    do_start(4);
    store(32'd0, 32'd1);
    store(32'd4, 32'd2);
    #1 reset = 0;
    #1 model_clear(); check_all();
    #2 reset = 1;
    do_start(4);
    for (int i = 0; i < 4; i++) store(32'(4 * i), 32'(i + 1));
    chk("post_reset_pass", 32'(pass), 32'd1);

    // Table write coincident with start lands first
    exp_we = 1; exp_idx = 0; exp_addr = 32'd200; exp_data = 32'd5;
    start = 1; exp_count = 3'd1;
    tick();
    store(32'd200, 32'd5);
    chk("we_start_pass", 32'(pass), 32'd1);

    // Match on the expiry cycle wins
    do_start(1);
    repeat (TIMEOUT - 1) tick();
    store(32'd200, 32'd5);
    chk("match_vs_expiry", 32'(pass), 32'd1);

    // Randomized runs against the model
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < DEPTH; i++)
        if ($urandom_range(0, 2) == 0)
          prog(i, {24'd0, 6'($urandom_range(0, 31)), 2'b00}, 32'($urandom_range(0, 15)));
      do_start($urandom_range(0, DEPTH));
      for (int c = 0; c < 14; c++) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4: begin
            memwrite = 1; dataadr = m_a[m_pos % DEPTH]; writedata = m_d[m_pos % DEPTH];
          end
          5: begin memwrite = 1; dataadr = IGN; writedata = $urandom; end
          6: begin
            memwrite = 1; dataadr = m_a[m_pos % DEPTH];
            writedata = m_d[m_pos % DEPTH] ^ 32'(1 << $urandom_range(0, 31));
          end
          7: begin
            exp_we = 1; exp_idx = IW'($urandom_range(0, DEPTH - 1));
            exp_addr = $urandom; exp_data = $urandom;
          end
          8: begin start = 1; exp_count = (IW+1)'($urandom_range(0, DEPTH)); end
          default: ;
        endcase
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
